boot_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of `pipe_MIPS32`. It receives a length-prefixed image over a byte-wide valid/ready link and assembles big-endian 32-bit instruction words. It writes them into the core's memory through a write port, starting at word address 0. Only after the last word has landed does it release the core (`cpu_run`), which replaces direct pokes into `Mem`, `PC` and `HALTED`.

---
 rtl/boot_loader_if.sv | 22 ++
 rtl/boot_loader.sv | 126 ++++++++++++
 tb/tb_boot_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream input link and core memory write port of the boot loader.
// slave: loader side; master: stream source / memory side.
interface boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Length-prefixed byte-stream loader: writes big-endian words from address 0, then releases the core.
// Optional trailing checksum byte: define BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic            clk1,
  input  logic            reset,
  input  logic            restart,
  boot_loader_if.slave    bus,
  output logic            cpu_run,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);
  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA, CHK, DRAIN, DONE, ERR
  } state_t;

  localparam logic [16:0]     CAP    = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WORD_1 = {{ADDR_W{1'b0}}, 1'b1};
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA  = CHK;
  localparam state_t AFTER_EMPTY = CHK;
`else
  localparam state_t AFTER_DATA  = DRAIN;
  localparam state_t AFTER_EMPTY = DONE;
`endif

  state_t          state, state_nxt;
  logic            accept, take_restart, word_end, last_word;
  logic [7:0]      n_hi;
  logic [15:0]     n_words;
  logic [1:0]      bcnt;
  logic [23:0]     shift;
  logic [ADDR_W:0] widx;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign bus.in_ready = (state == CNT_HI) || (state == CNT_LO) ||
                        (state == DATA)   || (state == CHK);
  assign accept       = bus.in_valid & bus.in_ready;
  assign take_restart = restart & ((state == DONE) | (state == ERR));
  assign word_end     = accept & (state == DATA) & (bcnt == 2'd3);
  assign last_word    = (16'(widx) + 16'd1) == n_words;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) state <= CNT_HI;
    else       state <= state_nxt;
  end

  // DRAIN holds off DONE for one cycle so the final write lands before the core runs
  always_comb begin
    state_nxt = state;
    case (state)
      CNT_HI: if (accept) state_nxt = CNT_LO;
      CNT_LO: if (accept) begin
        if ({1'b0, n_hi, bus.in_data} > CAP)       state_nxt = ERR;
        else if ({n_hi, bus.in_data} == 16'd0)     state_nxt = AFTER_EMPTY;
        else                                       state_nxt = DATA;
      end
      DATA:   if (word_end && last_word) state_nxt = AFTER_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK:    if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
`endif
      DRAIN:  state_nxt = DONE;
      DONE,
      ERR:    if (restart) state_nxt = CNT_HI;
      default: state_nxt = CNT_HI;
    endcase
  end

  // Status outputs are registered one edge behind the state that produces them
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      n_words       <= '0;
      bcnt          <= '0;
      widx          <= '0;
      words_loaded  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_run       <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      bus.mem_we <= word_end;
      if (take_restart) begin
        widx         <= '0;
        words_loaded <= '0;
        cpu_run      <= 1'b0;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
      end else begin
        cpu_run   <= (state == DONE);
        load_done <= (state == DONE);
        load_err  <= (state == ERR);
        if (bus.mem_we) words_loaded <= words_loaded + WORD_1;
      end
      if (accept && state == CNT_LO) begin
        n_words <= {n_hi, bus.in_data};
        bcnt    <= '0;
        widx    <= '0;
      end
      if (accept && state == DATA) bcnt <= bcnt + 2'd1;
      if (word_end) begin
        bus.mem_addr  <= widx[ADDR_W-1:0];
        bus.mem_wdata <= {shift, bus.in_data};
        widx          <= widx + WORD_1;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset)                          csum <= '0;
    else if (accept && state == CNT_LO) csum <= '0;
    else if (accept && state == DATA)   csum <= csum + bus.in_data;
  end
`endif

  always_ff @(posedge clk1) begin
    if (accept && state == CNT_HI) n_hi  <= bus.in_data;
    if (accept && state == DATA)   shift <= {shift[15:0], bus.in_data};
  end
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever mem_we is seen.
`timescale 1ns/1ps
module tb_boot_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          restart = 1'b0;
  logic          cpu_run, load_done, load_err;
  logic [AW:0]   words_loaded;

  boot_loader_if #(.ADDR_W(AW)) bif ();

  boot_loader #(.ADDR_W(AW)) dut (
    .clk1         (clk),
    .reset        (rst),
    .restart      (restart),
    .bus          (bif.slave),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic prev_we = 1'b0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;

  // ADDI R1,10 / ADDI R2,20 / ADDI R3,25 / OR / OR / ADD R4 / OR / ADD R5 / HLT
  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                            32'h0ce77800, 32'h0ce77800, 32'h00222000,
                            32'h0ce77800, 32'h00832800, 32'hfc000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bif.mem_we === 1'b1) begin
      writes++;
      check("no_back_to_back_we", prev_we, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bif.mem_addr, bif.mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", bif.mem_addr, exp_e[AW+31:32]);
        check("wr_data", bif.mem_wdata, exp_e[31:0]);
      end
    end
    prev_we = bif.mem_we;
  end

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bif.in_valid = 1'b0;
    end
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    if (bif.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_offer: got %b, expected 1 for byte %0h", bif.in_ready, b);
    end
    @(posedge clk);
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    exp_q.push_back({a, data});
  endtask

  task automatic load_prog(input int maxgap);
    logic [7:0] sum;
    sum = 8'h00;
    writes = 0;
    send(8'h00, $urandom_range(0, maxgap));
    send(8'h09, $urandom_range(0, maxgap));
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 4; b++) begin
        sum = sum + prog[w][31-8*b -: 8];
        send(prog[w][31-8*b -: 8], $urandom_range(0, maxgap));
      end
      push_exp(w, prog[w]);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(sum, $urandom_range(0, maxgap));
`endif
  endtask

  // Called just after the edge that accepted the final byte of an image
  task automatic expect_release(input int nwords);
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("cpu_run_early1", cpu_run, 1'b0);
`ifndef BOOT_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("cpu_run_early2", cpu_run, 1'b0);
    check("words_loaded_pre", words_loaded, nwords);
`endif
    @(negedge clk);
    check("cpu_run", cpu_run, 1'b1);
    check("load_done", load_done, 1'b1);
    check("load_err", load_err, 1'b0);
    check("in_ready_done", bif.in_ready, 1'b0);
    check("words_loaded", words_loaded, nwords);
    check("write_count", writes, nwords);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    bif.in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_cpu_run", cpu_run, 1'b0);
    check("rs_load_done", load_done, 1'b0);
    check("rs_load_err", load_err, 1'b0);
    check("rs_words", words_loaded, 0);
    check("rs_in_ready", bif.in_ready, 1'b1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", bif.in_ready, 1'b1);
    check("rst_mem_we", bif.mem_we, 1'b0);
    check("rst_mem_addr", bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_words", words_loaded, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // full image, in_valid held high
    load_prog(0);
    expect_release(9);

    // same image with 0..3 cycle gaps
    do_restart();
    load_prog(3);
    expect_release(9);

    // oversize count N = 1025
    do_restart();
    writes = 0;
    send(8'h04, 0);
    send(8'h01, 0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("ovf_in_ready", bif.in_ready, 1'b0);
    @(negedge clk);
    check("ovf_load_err", load_err, 1'b1);
    check("ovf_cpu_run", cpu_run, 1'b0);
    check("ovf_in_ready2", bif.in_ready, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_no_writes", writes, 0);
    do_restart();
    load_prog(1);
    expect_release(9);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // one-word image, good then bad checksum
    for (int t = 0; t < 2; t++) begin
      do_restart();
      writes = 0;
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      send(8'h03, 0);
      send(8'h04, 0);
      push_exp(0, 32'h01020304);
      send((t == 0) ? 8'h0a : 8'h0b, 0);
      @(negedge clk);
      bif.in_valid = 1'b0;
      @(negedge clk);
      check("cs_load_done", load_done, (t == 0));
      check("cs_load_err", load_err, (t == 1));
      check("cs_cpu_run", cpu_run, (t == 0));
      check("cs_writes", writes, 1);
    end
`else
    // empty image
    do_restart();
    writes = 0;
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("n0_cpu_run_early", cpu_run, 1'b0);
    @(negedge clk);
    check("n0_load_done", load_done, 1'b1);
    check("n0_cpu_run", cpu_run, 1'b1);
    check("n0_words", words_loaded, 0);
    check("n0_writes", writes, 0);
`endif

    // N = 1024 is exactly capacity and must be accepted
    do_restart();
    send(8'h04, 0);
    send(8'h00, 0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    check("cap_load_err", load_err, 1'b0);
    check("cap_in_ready", bif.in_ready, 1'b1);
    rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // reset after 2.5 words; restart in DATA must be ignored
    writes = 0;
    send(8'h00, 0);
    send(8'h09, 0);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) send(prog[w][31-8*b -: 8], 0);
      push_exp(w, prog[w]);
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("mid_words", words_loaded, 2);
    check("mid_in_ready", bif.in_ready, 1'b1);
    send(prog[2][31:24], 0);
    send(prog[2][23:16], 0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("mid_writes", writes, 2);
    rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    load_prog(0);
    expect_release(9);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
